// File: rtl/hist_2d.sv
// Two-dimensional I/Q histogram: bins each accepted sample by linear search, then
// either reports the updated bin immediately (stream) or dumps and clears the grid (batch).
module hist_2d #(
   parameter int MAX_BINS = 16
) (
   input  logic               clk100,
   input  logic               reset_n,
   input  logic               data_in,
   input  logic signed [31:0] i_val,
   input  logic signed [31:0] q_val,
   input  logic [7:0]         i_bin_num,
   input  logic [7:0]         q_bin_num,
   input  logic [15:0]        i_bin_width,
   input  logic [15:0]        q_bin_width,
   input  logic signed [15:0] i_min,
   input  logic signed [15:0] q_min,
   input  logic [15:0]        num_data_pts,
   input  logic               stream_mode,
   output logic               i_q_found,
   output logic               bin_found,
   output logic [7:0]         i_bin_coord,
   output logic [7:0]         q_bin_coord,
   output logic [15:0]        bin_val
);

   localparam int IW = (MAX_BINS > 1) ? $clog2(MAX_BINS) : 1;
   localparam logic [8:0] MAXB = 9'(MAX_BINS);

   typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, DUMP} state_t;
   state_t state, state_nxt;

   logic [15:0]        cnt [MAX_BINS][MAX_BINS];
   logic signed [31:0] i_smp, q_smp;
   logic               mode_lat;
   logic [7:0]         i_bin, q_bin, d_i, d_q, ni, nq;
   logic signed [32:0] i_thr, q_thr, i_off, q_off, i_step, q_step;
   logic [15:0]        npts, smp_cnt, smp_inc, cur_cnt, new_cnt;
   logic               i_done, q_done, last_bin;

   function automatic logic [7:0] eff_bins(input logic [7:0] n);
      if (n == 8'd0) return 8'd1;
      if ({1'b0, n} > MAXB) return MAXB[7:0];
      return n;
   endfunction

   function automatic logic [15:0] nz16(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      ni       = eff_bins(i_bin_num);
      nq       = eff_bins(q_bin_num);
      i_step   = {17'd0, nz16(i_bin_width)};
      q_step   = {17'd0, nz16(q_bin_width)};
      // offsets at 33 bits so a full-range sample minus min cannot wrap
      i_off    = {i_smp[31], i_smp} - {{17{i_min[15]}}, i_min};
      q_off    = {q_smp[31], q_smp} - {{17{q_min[15]}}, q_min};
      i_done   = (i_off < i_thr) || (i_bin == ni - 8'd1);
      q_done   = (q_off < q_thr) || (q_bin == nq - 8'd1);
      npts     = nz16(num_data_pts);
      smp_inc  = smp_cnt + 16'd1;
      cur_cnt  = cnt[q_bin[IW-1:0]][i_bin[IW-1:0]];
      new_cnt  = sat_inc(cur_cnt);
      last_bin = (d_i == ni - 8'd1) && (d_q == nq - 8'd1);
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (data_in) state_nxt = SEARCH;
         SEARCH:  if (i_done && q_done) state_nxt = UPDATE;
         UPDATE:  state_nxt = (!mode_lat && smp_inc == npts) ? DUMP : IDLE;
         DUMP:    if (last_bin) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         for (int q = 0; q < MAX_BINS; q++)
            for (int i = 0; i < MAX_BINS; i++)
               cnt[q][i] <= '0;
         i_smp       <= '0;
         q_smp       <= '0;
         mode_lat    <= 1'b0;
         i_bin       <= '0;
         q_bin       <= '0;
         i_thr       <= '0;
         q_thr       <= '0;
         d_i         <= '0;
         d_q         <= '0;
         smp_cnt     <= '0;
         i_q_found   <= 1'b0;
         bin_found   <= 1'b0;
         i_bin_coord <= '0;
         q_bin_coord <= '0;
         bin_val     <= '0;
      end else begin
         i_q_found <= 1'b0;
         bin_found <= 1'b0;
         unique case (state)
            IDLE: begin
               if (data_in) begin
                  i_smp    <= i_val;
                  q_smp    <= q_val;
                  mode_lat <= stream_mode;
                  i_bin    <= '0;
                  q_bin    <= '0;
                  i_thr    <= i_step;
                  q_thr    <= q_step;
               end
            end
            SEARCH: begin
               if (!i_done) begin
                  i_bin <= i_bin + 8'd1;
                  i_thr <= i_thr + i_step;
               end
               if (!q_done) begin
                  q_bin <= q_bin + 8'd1;
                  q_thr <= q_thr + q_step;
               end
               if (i_done && q_done) begin
                  i_q_found   <= 1'b1;
                  i_bin_coord <= i_bin;
                  q_bin_coord <= q_bin;
               end
            end
            UPDATE: begin
               cnt[q_bin[IW-1:0]][i_bin[IW-1:0]] <= new_cnt;
               if (mode_lat) begin
                  bin_found <= 1'b1;
                  bin_val   <= new_cnt;
               end else begin
                  smp_cnt <= smp_inc;
                  d_i     <= '0;
                  d_q     <= '0;
               end
            end
            DUMP: begin
               // report and clear one bin per cycle, q outer / i inner
               bin_found   <= 1'b1;
               i_bin_coord <= d_i;
               q_bin_coord <= d_q;
               bin_val     <= cnt[d_q[IW-1:0]][d_i[IW-1:0]];
               cnt[d_q[IW-1:0]][d_i[IW-1:0]] <= '0;
               if (d_i == ni - 8'd1) begin
                  d_i <= '0;
                  d_q <= d_q + 8'd1;
               end else begin
                  d_i <= d_i + 8'd1;
               end
               if (last_bin) smp_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hist_2d.sv
// Directed bench for hist_2d: vector tables for binning/stream reports plus
// hand-written sequences for batch dumps, busy drop, reset mid-dump and saturation.
module tb_hist_2d;

   logic               clk100 = 1'b0;
   logic               reset_n = 1'b0;
   logic               data_in = 1'b0;
   logic signed [31:0] i_val = '0, q_val = '0;
   logic [7:0]         nb = 8'd10;
   logic [15:0]        wid = 16'd1;
   logic signed [15:0] mn = '0;
   logic [15:0]        npts = 16'd1;
   logic               strm = 1'b0;
   logic               i_q_found, bin_found;
   logic [7:0]         i_bin_coord, q_bin_coord;
   logic [15:0]        bin_val;

   hist_2d #(.MAX_BINS(16)) dut (
      .clk100(clk100), .reset_n(reset_n), .data_in(data_in),
      .i_val(i_val), .q_val(q_val),
      .i_bin_num(nb), .q_bin_num(nb),
      .i_bin_width(wid), .q_bin_width(wid),
      .i_min(mn), .q_min(mn),
      .num_data_pts(npts), .stream_mode(strm),
      .i_q_found(i_q_found), .bin_found(bin_found),
      .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord), .bin_val(bin_val)
   );

   always #5 clk100 = ~clk100;

   int cyc = 0;
   always @(posedge clk100) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  i;
      logic [7:0]  q;
      logic [15:0] v;
      int          cyc;
   } ev_t;
   ev_t iq_q[$];
   ev_t bf_q[$];

   always @(negedge clk100) begin
      if (reset_n) begin
         if (i_q_found) iq_q.push_back('{i_bin_coord, q_bin_coord, 16'd0, cyc});
         if (bin_found) bf_q.push_back('{i_bin_coord, q_bin_coord, bin_val, cyc});
      end
   end

   typedef struct {
      int iv;
      int qv;
      int ei;
      int eq;
      int elen;
      int ev;
   } vec_t;
   vec_t vt[8];

   int total = 0;
   int bad   = 0;
   int exp_h[16][16];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk100);
      #1;
   endtask

   task automatic drive(input int iv, input int qv, output int c);
      tick();
      i_val   = iv;
      q_val   = qv;
      data_in = 1'b1;
      c       = cyc;
      tick();
      data_in = 1'b0;
   endtask

   task automatic hard_reset();
      tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      iq_q.delete();
      bf_q.delete();
   endtask

   task automatic clr_exp();
      for (int q = 0; q < 16; q++)
         for (int i = 0; i < 16; i++)
            exp_h[q][i] = 0;
   endtask

   task automatic wait_bf(input int n, input int budget);
      for (int t = 0; t < budget && bf_q.size() < n; t++) tick();
   endtask

   task automatic check_dump(input string nm, input int n);
      bit contig;
      chk({nm, " dump count"}, bf_q.size(), n * n);
      if (bf_q.size() < n * n) return;
      contig = 1'b1;
      for (int k = 0; k < n * n; k++) begin
         chk($sformatf("%s bin(%0d,%0d)", nm, k % n, k / n),
             {bf_q[k].i, bf_q[k].q, bf_q[k].v},
             {8'(k % n), 8'(k / n), 16'(exp_h[k / n][k % n])});
         if (bf_q[k].cyc != bf_q[0].cyc + k) contig = 1'b0;
      end
      chk({nm, " dump contiguous"}, contig, 1);
   endtask

   task automatic run_vectors(input string nm, input int n, input bit sm);
      int c0;
      for (int k = 0; k < n; k++) begin
         drive(vt[k].iv, vt[k].qv, c0);
         repeat (14) tick();
         chk($sformatf("%s v%0d iq count", nm, k), iq_q.size(), k + 1);
         if (iq_q.size() < k + 1) continue;
         chk($sformatf("%s v%0d coords", nm, k), {iq_q[k].i, iq_q[k].q},
             {8'(vt[k].ei), 8'(vt[k].eq)});
         chk($sformatf("%s v%0d search len", nm, k), iq_q[k].cyc - c0 - 1, vt[k].elen);
         if (sm) begin
            chk($sformatf("%s v%0d bf count", nm, k), bf_q.size(), k + 1);
            if (bf_q.size() < k + 1) continue;
            chk($sformatf("%s v%0d report", nm, k), {bf_q[k].i, bf_q[k].q, bf_q[k].v},
                {8'(vt[k].ei), 8'(vt[k].eq), 16'(vt[k].ev)});
            chk($sformatf("%s v%0d bf lag", nm, k), bf_q[k].cyc - iq_q[k].cyc, 1);
         end
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      $fatal(1);
   end

   initial begin
      int c;

      // reset state
      repeat (3) tick();
      chk("reset i_q_found", i_q_found, 0);
      chk("reset bin_found", bin_found, 0);
      chk("reset coords", {i_bin_coord, q_bin_coord}, 0);
      chk("reset bin_val", bin_val, 0);
      reset_n = 1'b1;

      // batch basic: 10x10, width 1, min 0, five samples
      hard_reset();
      nb = 8'd10; wid = 16'd1; mn = 16'sd0; npts = 16'd5; strm = 1'b0;
      vt[0] = '{-3, -3, 0, 0, 1, 1};
      vt[1] = '{-2, -2, 0, 0, 1, 2};
      vt[2] = '{-1, -1, 0, 0, 1, 3};
      vt[3] = '{ 0,  0, 0, 0, 1, 4};
      vt[4] = '{ 1,  1, 1, 1, 2, 1};
      run_vectors("batch", 5, 1'b0);
      wait_bf(100, 300);
      clr_exp();
      exp_h[0][0] = 4;
      exp_h[1][1] = 1;
      check_dump("batch", 10);

      // stream mode: same samples, reports follow i_q_found, no dump
      hard_reset();
      strm = 1'b1;
      run_vectors("stream", 5, 1'b1);
      repeat (120) tick();
      chk("stream no dump", bf_q.size(), 5);

      // width 4, min -8, clamping at both edges
      hard_reset();
      nb = 8'd10; wid = 16'd4; mn = -16'sd8; strm = 1'b1;
      vt[0] = '{  -9,   31, 0, 9, 10, 1};
      vt[1] = '{  -8, 1000, 0, 9, 10, 2};
      vt[2] = '{  -5,   -4, 0, 1,  2, 1};
      vt[3] = '{  -4,   -5, 1, 0,  2, 1};
      vt[4] = '{  31,    0, 9, 2, 10, 1};
      vt[5] = '{1000,   -9, 9, 0, 10, 1};
      run_vectors("clamp", 6, 1'b1);

      // busy drop and re-arm: second identical batch must dump identical values
      hard_reset();
      nb = 8'd10; wid = 16'd4; mn = -16'sd8; npts = 16'd2; strm = 1'b0;
      for (int r = 0; r < 2; r++) begin
         iq_q.delete();
         bf_q.delete();
         drive(31, 31, c);
         repeat (3) tick();
         i_val = 0; q_val = 0; data_in = 1'b1;
         tick();
         data_in = 1'b0;
         repeat (12) tick();
         drive(-9, -9, c);
         wait_bf(100, 300);
         repeat (3) tick();
         chk($sformatf("rearm%0d iq count", r), iq_q.size(), 2);
         if (iq_q.size() >= 2) begin
            chk($sformatf("rearm%0d first", r), {iq_q[0].i, iq_q[0].q}, 16'h0909);
            chk($sformatf("rearm%0d second", r), {iq_q[1].i, iq_q[1].q}, 16'h0000);
         end
         clr_exp();
         exp_h[9][9] = 1;
         exp_h[0][0] = 1;
         check_dump($sformatf("rearm%0d", r), 10);
      end

      // reset in the middle of a dump, before bin (9,9) is reported
      hard_reset();
      nb = 8'd10; wid = 16'd1; mn = 16'sd0; npts = 16'd1; strm = 1'b0;
      drive(9, 9, c);
      wait_bf(20, 200);
      chk("middump reached", bf_q.size() >= 20, 1);
      reset_n = 1'b0;
      #1;
      chk("middump i_q_found", i_q_found, 0);
      chk("middump bin_found", bin_found, 0);
      chk("middump coords", {i_bin_coord, q_bin_coord}, 0);
      chk("middump bin_val", bin_val, 0);
      tick();
      tick();
      reset_n = 1'b1;
      iq_q.delete();
      bf_q.delete();
      drive(3, 5, c);
      wait_bf(100, 300);
      clr_exp();
      exp_h[5][3] = 1;
      check_dump("postreset", 10);

      // saturation: 65537 back-to-back stream samples into bin (0,0)
      hard_reset();
      nb = 8'd10; wid = 16'd1; mn = 16'sd0; strm = 1'b1;
      i_val = 0; q_val = 0;
      data_in = 1'b1;
      for (int t = 0; t < 230000 && bf_q.size() < 65537; t++) tick();
      data_in = 1'b0;
      chk("sat count", bf_q.size() >= 65537, 1);
      if (bf_q.size() >= 65537) begin
         chk("sat 65534th", bf_q[65533].v, 16'hFFFE);
         chk("sat 65535th", bf_q[65534].v, 16'hFFFF);
         chk("sat 65537th", bf_q[65536].v, 16'hFFFF);
         chk("sat coords", {bf_q[65536].i, bf_q[65536].q}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
